mem_wb_pipe_stage: RTL and testbench
====================================

// Module: mem_wb_pipe_stage
// PURPOSE
//   Parametrised MEM->WB elastic pipeline stage for the vector CPU; replaces the fixed 16-bit MEM/WB latch.
//   Carries regWrite, resultSrc, rd, pc+2, ALU result, load data and store data across LANES vector lanes.
//   Adds valid/ready handshake with a 2-entry skid buffer (full throughput under backpressure), sync flush,
//   and the WB result mux, so the register file gets a single write port (out_result/out_we).
// PARAMETERS
//   DATA_W  16  bits per lane
//   LANES   1   vector lanes; lane i occupies bits [i*DATA_W +: DATA_W]
//   RD_W    4   destination register index width
//   PC_W    16  pc+2 width (PC_W <= DATA_W)
// PORTS
//   clk             in   1              clock, rising edge
//   reset           in   1              asynchronous, active-high
//   flush           in   1              sync: drop all held and incoming beats
//   in_valid        in   1              MEM beat valid
//   in_ready        out  1              stage can accept a beat this cycle
//   in_regwrite     in   1              beat writes register file
//   in_result_src   in   2              00 alu, 01 read data, 10 pc+2, 11 write data
//   in_rd           in   RD_W           destination register
//   in_pc_plus2     in   PC_W           pc+2 of the instruction
//   in_alu_res      in   LANES*DATA_W   ALU result
//   in_read_data    in   LANES*DATA_W   data-memory read data
//   in_write_data   in   LANES*DATA_W   store data (writeDataM)
//   out_valid       out  1              WB beat valid
//   out_ready       in   1              WB consumes beat this cycle
//   out_regwrite, out_result_src, out_rd, out_pc_plus2, out_alu_res, out_read_data, out_write_data
//                   out  as inputs      registered payload of head beat
//   out_result      out  LANES*DATA_W   WB mux output (combinational from head payload)
//   out_we          out  1              out_valid & out_ready & out_regwrite
// BEHAVIOUR
//   - accept = in_valid & in_ready & ~flush;  fire = out_valid & out_ready.
//   - Storage: MAIN (head, drives out_*) and SKID. States EMPTY, ONE, FULL; out_valid = (state != EMPTY).
//   - in_ready = (state != FULL), decoded from registered state; no combinational path from out_ready.
//   - EMPTY: accept -> ONE, MAIN<=in.
//   - ONE:   accept&fire -> ONE, MAIN<=in;  fire only -> EMPTY;  accept only -> FULL, SKID<=in;  else hold.
//   - FULL:  no accept possible; fire -> ONE, MAIN<=SKID;  else hold.
//   - flush: next state EMPTY from any state, overrides all transitions; input in flush cycle is discarded;
//     a fire in the flush cycle still counts as delivered. Payload regs not cleared by flush.
//   - Latency: accept at edge N -> out_valid after edge N. Throughput 1 beat/cycle with out_ready high.
//   - Order preserved; no beat lost or duplicated under any in_valid/out_ready pattern.
//   - Payload regs load only on a transition that writes them; otherwise hold.
//   - out_result: 00 -> out_alu_res; 01 -> out_read_data; 10 -> pc+2 zero-extended to DATA_W in lane 0,
//     other lanes 0; 11 -> out_write_data. Pure bit select, no arithmetic.
//   - out_we is 0 whenever out_valid=0, even if out_regwrite=1 is held in MAIN.
//   - Reset (async, any time incl. FULL): state EMPTY, all payload regs 0 in MAIN and SKID; hence
//     out_valid=0, out_we=0, out_regwrite=0, out_result_src=0, out_rd=0, all data outputs 0, out_result=0.
//     in_ready=1 as soon as reset deasserts.
// TESTING
//   1 reset asserted between edges -> out_valid=0, out_we=0, out_result=0, in_ready=1 immediately, no clock edge.
//   2 out_ready=1, beats alu=0x0011,0x0022,0x0033 rs=00 regwrite=1 -> out_result same order 1 cycle later,
//     out_we=1 each cycle, in_ready stays 1.
//   3 out_ready=0, send A,B,C -> A,B accepted, FULL, in_ready=0, C held; out_ready=1 -> A,B,C in order.
//   4 rs=01 read=0xBEEF -> 0xBEEF; rs=10 pc=0x0042, LANES=4 -> lane0 0x0042, lanes1-3 0; rs=11 wd=0x1234 -> 0x1234.
//   5 FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed and incoming beats never appear.
//   6 random in_valid/out_ready 10k cycles vs FIFO model -> exact sequence match, in_ready never 1 in FULL.

Source files
------------

// File: rtl/mem_wb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_pipe_stage
// Brief    : MEM->WB elastic pipeline stage with a 2-entry skid buffer,
//            synchronous flush and the write-back result mux. MAIN holds the
//            head beat and drives out_*. SKID catches the one extra beat that
//            can arrive while the consumer stalls. in_ready depends only on
//            registered state, so there is no combinational path from
//            out_ready back to in_ready.
// Revision : 1.0 - initial parametrised vector-lane version
// ============================================================================
module mem_wb_pipe_stage #(
  parameter int DATA_W = 16,
  parameter int LANES  = 1,
  parameter int RD_W   = 4,
  parameter int PC_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_regwrite,
  input  logic [1:0]              in_result_src,
  input  logic [RD_W-1:0]         in_rd,
  input  logic [PC_W-1:0]         in_pc_plus2,
  input  logic [LANES*DATA_W-1:0] in_alu_res,
  input  logic [LANES*DATA_W-1:0] in_read_data,
  input  logic [LANES*DATA_W-1:0] in_write_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_regwrite,
  output logic [1:0]              out_result_src,
  output logic [RD_W-1:0]         out_rd,
  output logic [PC_W-1:0]         out_pc_plus2,
  output logic [LANES*DATA_W-1:0] out_alu_res,
  output logic [LANES*DATA_W-1:0] out_read_data,
  output logic [LANES*DATA_W-1:0] out_write_data,
  output logic [LANES*DATA_W-1:0] out_result,
  output logic                    out_we
);

  localparam int c_VEC_W = LANES * DATA_W;
  localparam int c_PAY_W = 1 + 2 + RD_W + PC_W + 3 * c_VEC_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_PAY_W-1:0]   r_main;
  logic [c_PAY_W-1:0]   r_skid;
  logic [c_PAY_W-1:0]   w_in_pay;
  logic                 w_accept;
  logic                 w_fire;
  logic                 w_load_main;
  logic                 w_main_from_skid;
  logic                 w_load_skid;
  logic [c_VEC_W-1:0]   w_pc_ext;

  // Payload fields travel together as one packed word through MAIN and SKID.
  assign w_in_pay = {in_regwrite, in_result_src, in_rd, in_pc_plus2,
                     in_alu_res, in_read_data, in_write_data};

  assign {out_regwrite, out_result_src, out_rd, out_pc_plus2,
          out_alu_res, out_read_data, out_write_data} = r_main;

  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = (r_state != ST_FULL);
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_fire    = out_valid & out_ready;
  assign out_we    = w_fire & out_regwrite;

  // Next-state and payload-load decode; flush forces EMPTY and suppresses all loads.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_fire) begin
            w_load_main = 1'b1;
          end else if (w_fire) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_fire) begin
            w_state_nxt      = ST_ONE;
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Head register: refilled from the input or promoted from SKID on drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
    end else if (w_load_main) begin
      r_main <= w_main_from_skid ? r_skid : w_in_pay;
    end
  end

  // Skid register: captures the beat that arrives while the head is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid <= '0;
    end else if (w_load_skid) begin
      r_skid <= w_in_pay;
    end
  end

  // pc+2 zero-extended into lane 0, all other lanes zero.
  always_comb begin
    w_pc_ext              = '0;
    w_pc_ext[PC_W-1:0]    = out_pc_plus2;
  end

  // Write-back result select: a pure mux over the head payload.
  always_comb begin
    out_result = out_alu_res;
    case (out_result_src)
      2'b00:   out_result = out_alu_res;
      2'b01:   out_result = out_read_data;
      2'b10:   out_result = w_pc_ext;
      2'b11:   out_result = out_write_data;
      default: out_result = out_alu_res;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_pipe_stage
// Brief    : Self-checking bench for mem_wb_pipe_stage (LANES=4). A FIFO model
//            of at most two beats predicts in_ready, out_valid, head payload,
//            out_result and out_we every cycle.
// Revision : 1.0 - initial
// ============================================================================
module tb_mem_wb_pipe_stage;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int RD_W   = 4;
  localparam int PC_W   = 16;
  localparam int VW     = LANES * DATA_W;

  typedef struct packed {
    logic          rw;
    logic [1:0]    rs;
    logic [3:0]    rd;
    logic [15:0]   pc;
    logic [63:0]   alu;
    logic [63:0]   rdd;
    logic [63:0]   wd;
  } beat_t;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            in_regwrite;
  logic [1:0]      in_result_src;
  logic [RD_W-1:0] in_rd;
  logic [PC_W-1:0] in_pc_plus2;
  logic [VW-1:0]   in_alu_res;
  logic [VW-1:0]   in_read_data;
  logic [VW-1:0]   in_write_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_regwrite;
  logic [1:0]      out_result_src;
  logic [RD_W-1:0] out_rd;
  logic [PC_W-1:0] out_pc_plus2;
  logic [VW-1:0]   out_alu_res;
  logic [VW-1:0]   out_read_data;
  logic [VW-1:0]   out_write_data;
  logic [VW-1:0]   out_result;
  logic            out_we;

  int    checks = 0;
  int    errors = 0;
  beat_t q[$];
  beat_t idle;

  mem_wb_pipe_stage #(
    .DATA_W(DATA_W), .LANES(LANES), .RD_W(RD_W), .PC_W(PC_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_result_src(in_result_src), .in_rd(in_rd),
    .in_pc_plus2(in_pc_plus2), .in_alu_res(in_alu_res),
    .in_read_data(in_read_data), .in_write_data(in_write_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_regwrite(out_regwrite), .out_result_src(out_result_src),
    .out_rd(out_rd), .out_pc_plus2(out_pc_plus2), .out_alu_res(out_alu_res),
    .out_read_data(out_read_data), .out_write_data(out_write_data),
    .out_result(out_result), .out_we(out_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic rw, input logic [1:0] rs, input logic [3:0] rd,
                               input logic [15:0] pc, input logic [63:0] alu,
                               input logic [63:0] rdd, input logic [63:0] wd);
    beat_t b;
    b.rw = rw; b.rs = rs; b.rd = rd; b.pc = pc; b.alu = alu; b.rdd = rdd; b.wd = wd;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.rw  = 1'($urandom_range(0, 1));
    b.rs  = 2'($urandom_range(0, 3));
    b.rd  = 4'($urandom_range(0, 15));
    b.pc  = 16'($urandom);
    b.alu = {$urandom, $urandom};
    b.rdd = {$urandom, $urandom};
    b.wd  = {$urandom, $urandom};
    return b;
  endfunction

  // WB result as defined by the select encoding.
  function automatic logic [63:0] wb_result(input beat_t b);
    case (b.rs)
      2'b00:   return b.alu;
      2'b01:   return b.rdd;
      2'b10:   return {48'h0, b.pc};
      default: return b.wd;
    endcase
  endfunction

  // Entered at posedge+1: drive, check pre-edge outputs vs model, update model,
  // advance to the next posedge+1.
  task automatic cycle(input beat_t b, input bit iv, input bit ordy, input bit fl);
    bit exp_ready, exp_valid, fire, acc;
    logic exp_we;
    in_valid = iv; out_ready = ordy; flush = fl;
    in_regwrite = b.rw; in_result_src = b.rs; in_rd = b.rd; in_pc_plus2 = b.pc;
    in_alu_res = b.alu; in_read_data = b.rdd; in_write_data = b.wd;
    #3;
    exp_ready = (q.size() < 2);
    exp_valid = (q.size() != 0);
    exp_we    = exp_valid ? (ordy & q[0].rw) : 1'b0;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_we", 64'(out_we), 64'(exp_we));
    if (exp_valid) begin
      chk("payload", {out_regwrite, out_result_src, out_rd, out_pc_plus2},
          64'({q[0].rw, q[0].rs, q[0].rd, q[0].pc}));
      chk("alu", out_alu_res, q[0].alu);
      chk("rdata", out_read_data, q[0].rdd);
      chk("wdata", out_write_data, q[0].wd);
      chk("result", out_result, wb_result(q[0]));
    end
    fire = exp_valid & ordy;
    acc  = iv & exp_ready & ~fl;
    if (fl) q.delete();
    else begin
      if (fire) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_we"}, 64'(out_we), 64'd0);
    chk({tag, "_result"}, out_result, 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_ctl"}, {out_regwrite, out_result_src, out_rd, out_pc_plus2}, 64'd0);
    chk({tag, "_data"}, out_alu_res | out_read_data | out_write_data, 64'd0);
  endtask

  initial begin
    beat_t a, b, c, d;
    bit iv, ordy, fl;
    idle = '0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_regwrite = 1'b0; in_result_src = 2'b00; in_rd = '0; in_pc_plus2 = '0;
    in_alu_res = '0; in_read_data = '0; in_write_data = '0;

    // 1: reset asserted between edges takes effect with no clock edge
    #2 reset = 1'b1;
    #1 chk_reset_outputs("rst_async");
    @(posedge clk); #1;
    reset = 1'b0;
    #1 chk("rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 2: streaming with out_ready high, one-cycle latency
    a = mk(1, 2'b00, 4'd1, 16'h0002, 64'h0011, 64'h0, 64'h0);
    b = mk(1, 2'b00, 4'd2, 16'h0004, 64'h0022, 64'h0, 64'h0);
    c = mk(1, 2'b00, 4'd3, 16'h0006, 64'h0033, 64'h0, 64'h0);
    cycle(a, 1, 1, 0);
    chk("s2_res_a", out_result, 64'h0011);
    chk("s2_we_a", 64'(out_we), 64'd1);
    cycle(b, 1, 1, 0);
    chk("s2_res_b", out_result, 64'h0022);
    chk("s2_rdy_b", 64'(in_ready), 64'd1);
    cycle(c, 1, 1, 0);
    chk("s2_res_c", out_result, 64'h0033);
    chk("s2_we_c", 64'(out_we), 64'd1);
    cycle(idle, 0, 1, 0);
    chk("s2_drain", 64'(out_valid), 64'd0);

    // 3: backpressure fills both entries, C waits, then drains in order
    cycle(a, 1, 0, 0);
    cycle(b, 1, 0, 0);
    chk("s3_full_rdy", 64'(in_ready), 64'd0);
    chk("s3_head_a", out_alu_res, 64'h0011);
    cycle(c, 1, 0, 0);
    chk("s3_still_a", out_alu_res, 64'h0011);
    cycle(c, 1, 1, 0);
    chk("s3_head_b", out_alu_res, 64'h0022);
    cycle(c, 1, 1, 0);
    chk("s3_head_c", out_alu_res, 64'h0033);
    cycle(idle, 0, 1, 0);
    chk("s3_empty", 64'(out_valid), 64'd0);

    // 4: result select for read data, pc+2 and store data
    a = mk(1, 2'b01, 4'd4, 16'hAAAA, 64'hFFFF_FFFF_FFFF_FFFF, 64'hBEEF, 64'h5555);
    b = mk(1, 2'b10, 4'd5, 16'h0042, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    c = mk(0, 2'b11, 4'd6, 16'hAAAA, 64'hFFFF, 64'hEEEE, 64'h1234);
    cycle(a, 1, 1, 0);
    chk("s4_read", out_result, 64'hBEEF);
    cycle(b, 1, 1, 0);
    chk("s4_pc", out_result, 64'h0000_0000_0000_0042);
    cycle(c, 1, 1, 0);
    chk("s4_wd", out_result, 64'h1234);
    chk("s4_we_norw", 64'(out_we), 64'd0);
    cycle(idle, 0, 1, 0);

    // 5: flush from FULL with a beat offered
    d = mk(1, 2'b00, 4'd7, 16'h0008, 64'h0DDD, 64'h0, 64'h0);
    cycle(a, 1, 0, 0);
    cycle(b, 1, 0, 0);
    cycle(d, 1, 1, 1);
    chk("s5_valid", 64'(out_valid), 64'd0);
    chk("s5_ready", 64'(in_ready), 64'd1);
    chk("s5_we", 64'(out_we), 64'd0);
    cycle(idle, 0, 1, 0);
    cycle(idle, 0, 1, 0);

    // 6: randomized traffic with varying bias, occasional flush
    for (int i = 0; i < 10000; i++) begin
      case ((i / 1000) % 4)
        0:       begin iv = ($urandom_range(0, 3) != 0); ordy = ($urandom_range(0, 3) != 0); end
        1:       begin iv = ($urandom_range(0, 3) != 0); ordy = ($urandom_range(0, 3) == 0); end
        2:       begin iv = ($urandom_range(0, 3) == 0); ordy = ($urandom_range(0, 3) != 0); end
        default: begin iv = 1'b1; ordy = ($urandom_range(0, 1) != 0); end
      endcase
      fl = ($urandom_range(0, 99) == 0);
      cycle(rnd_beat(), iv, ordy, fl);
    end

    // async reset while FULL
    cycle(rnd_beat(), 1, 0, 0);
    cycle(rnd_beat(), 1, 0, 0);
    cycle(rnd_beat(), 1, 0, 0);
    chk("full_before_rst", 64'(in_ready), 64'd0);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("rst_full");
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cycle(rnd_beat(), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
